// File: rtl/keypad_scanner_debounced_if.sv
// rtl/keypad_scanner_debounced_if.sv - pad and key-event signals of the debounced keypad scanner
interface keypad_scanner_debounced_if #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int KEY_BITS = $clog2(ROWS * COLS)
);
  logic [ROWS-1:0]     rowReceivers;
  logic [COLS-1:0]     columnDrivers_reg;
  logic [KEY_BITS-1:0] key_reg;
  logic                keyValid;
  logic                keyHeld;
  logic                keyReleased;
  logic                multiKey;

  modport master (
    input  rowReceivers,
    output columnDrivers_reg, key_reg, keyValid, keyHeld, keyReleased, multiKey
  );

  modport slave (
    output rowReceivers,
    input  columnDrivers_reg, key_reg, keyValid, keyHeld, keyReleased, multiKey
  );
endinterface

// File: rtl/keypad_scanner_debounced.sv
// rtl/keypad_scanner_debounced.sv - column-scanning keypad reader with scan-level debounce and auto-repeat
module keypad_scanner_debounced #(
  parameter int ROWS           = 4,
  parameter int COLS           = 3,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 0,
  parameter int KEY_BITS       = $clog2(ROWS * COLS)
) (
  input  logic                       scanClock,
  input  logic                       resetN,
  keypad_scanner_debounced_if.master kp
);

  localparam int COL_W  = $clog2(COLS);
  localparam int SLOT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int REP_W  = (REPEAT_SCANS > 0) ? $clog2(REPEAT_SCANS + 1) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT_SCANS > 0) ? REPEAT_SCANS - 1 : 0);

  typedef enum logic [1:0] {IDLE, PRESS_CHECK, HELD} state_t;

  // scan sequencer and per-scan accumulator
  logic [COLS-1:0]     drv_q;
  logic [COL_W-1:0]    col_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [1:0]          acc_cnt_q;
  logic [KEY_BITS-1:0] acc_code_q;

  // combinational view of the current sample folded into the accumulator
  logic [1:0]          col_cnt;
  logic [KEY_BITS-1:0] hit_code;
  logic [2:0]          sum;
  logic [1:0]          scan_cnt;
  logic [KEY_BITS-1:0] scan_code;
  logic                slot_end;
  logic                scan_end;

  // debounce FSM state and registered outputs
  state_t              state_q, state_d;
  logic [KEY_BITS-1:0] cand_q, cand_d;
  logic [DEB_W-1:0]    cnt_q, cnt_d;
  logic [DEB_W-1:0]    rel_q, rel_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic                valid_q, valid_d;
  logic                held_q, held_d;
  logic                released_q, released_d;
  logic                multi_q, multi_d;
  logic                accept;

  assign slot_end = (drv_q != '0) && (slot_q == SLOT_W'(SETTLE_CYCLES - 1));
  assign scan_end = slot_end && (col_q == COL_W'(COLS - 1));

  // count contacts in the driven column (saturating at 2); lowest row supplies the code
  always_comb begin
    col_cnt  = 2'd0;
    hit_code = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (kp.rowReceivers[r]) begin
        hit_code = KEY_BITS'(r * COLS + int'(col_q));
        if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
      end
    end
    sum       = {1'b0, acc_cnt_q} + {1'b0, col_cnt};
    scan_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    scan_code = (acc_cnt_q == 2'd0) ? hit_code : acc_code_q;
  end

  // walk the columns one-hot; fold each end-of-slot sample into the scan result
  always_ff @(posedge scanClock or negedge resetN) begin
    if (!resetN) begin
      drv_q      <= '0;
      col_q      <= '0;
      slot_q     <= '0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= '0;
    end else if (drv_q == '0) begin
      drv_q  <= COLS'(1);
      col_q  <= '0;
      slot_q <= '0;
    end else if (slot_end) begin
      slot_q <= '0;
      if (scan_end) begin
        col_q      <= '0;
        drv_q      <= COLS'(1);
        acc_cnt_q  <= 2'd0;
        acc_code_q <= '0;
      end else begin
        col_q      <= col_q + COL_W'(1);
        drv_q      <= drv_q << 1;
        acc_cnt_q  <= scan_cnt;
        acc_code_q <= scan_code;
      end
    end else begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

  // debounce decisions, taken only on the edge that closes a full scan
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    rel_d      = rel_q;
    rep_d      = rep_q;
    key_d      = key_q;
    held_d     = held_q;
    multi_d    = multi_q;
    valid_d    = 1'b0;
    released_d = 1'b0;
    accept     = 1'b0;
    if (scan_end) begin
      multi_d = (scan_cnt == 2'd2);
      case (state_q)
        IDLE: begin
          if (scan_cnt == 2'd1) begin
            cand_d = scan_code;
            cnt_d  = DEB_W'(1);
            if (DEBOUNCE_SCANS == 1) accept = 1'b1;
            else state_d = PRESS_CHECK;
          end
        end
        PRESS_CHECK: begin
          if (scan_cnt == 2'd1) begin
            if (scan_code == cand_q) begin
              if (cnt_q == DEB_LAST) accept = 1'b1;
              else cnt_d = cnt_q + DEB_W'(1);
            end else begin
              cand_d = scan_code;
              cnt_d  = DEB_W'(1);
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (scan_cnt == 2'd0) begin
            if (rel_q == DEB_LAST) begin
              held_d     = 1'b0;
              released_d = 1'b1;
              rel_d      = '0;
              state_d    = IDLE;
            end else begin
              rel_d = rel_q + DEB_W'(1);
            end
          end else if ((scan_cnt == 2'd1) && (scan_code == key_q)) begin
            rel_d = '0;
            if (REPEAT_SCANS > 0) begin
              if (rep_q == REP_LAST) begin
                valid_d = 1'b1;
                rep_d   = '0;
              end else begin
                rep_d = rep_q + REP_W'(1);
              end
            end
          end else begin
            // a second key or a different key: stay latched on the original until full release
            rel_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
      if (accept) begin
        key_d   = cand_d;
        valid_d = 1'b1;
        held_d  = 1'b1;
        rel_d   = '0;
        rep_d   = '0;
        state_d = HELD;
      end
    end
  end

  // register FSM state, counters and outputs
  always_ff @(posedge scanClock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      rel_q      <= '0;
      rep_q      <= '0;
      key_q      <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      released_q <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      rel_q      <= rel_d;
      rep_q      <= rep_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      released_q <= released_d;
      multi_q    <= multi_d;
    end
  end

  assign kp.columnDrivers_reg = drv_q;
  assign kp.key_reg           = key_q;
  assign kp.keyValid          = valid_q;
  assign kp.keyHeld           = held_q;
  assign kp.keyReleased       = released_q;
  assign kp.multiKey          = multi_q;

endmodule

// File: tb/tb_keypad_scanner_debounced.sv
// tb/tb_keypad_scanner_debounced.sv - randomized and directed bench for the debounced keypad scanner
module tb_keypad_scanner_debounced;

  localparam int DEB = 3;
  localparam int SCAN_CLKS = 12;

  logic        scanClock = 1'b0;
  logic        resetN = 1'b0;
  logic [11:0] pressed = '0;
  logic [3:0]  rows_a, rows_b;

  int n_checks = 0;
  int n_errors = 0;
  int edge_no = 0;
  int first_valid_edge = 0;
  bit sel_rep = 1'b0;
  int m_r = 0;

  bit m_held;
  int m_key, m_code, m_run, m_rel, m_rep;

  bit         exp_v, exp_r, exp_held, exp_multi;
  logic [3:0] exp_key;
  int         obs_vcnt, obs_rcnt;
  logic       obs_vend, obs_rend, obs_held, obs_multi;
  logic [3:0] obs_key;

  keypad_scanner_debounced_if #(.ROWS(4), .COLS(3), .KEY_BITS(4)) kp_a ();
  keypad_scanner_debounced_if #(.ROWS(4), .COLS(3), .KEY_BITS(4)) kp_b ();

  keypad_scanner_debounced #(.ROWS(4), .COLS(3), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3),
                             .REPEAT_SCANS(0), .KEY_BITS(4)) dut (
    .scanClock(scanClock), .resetN(resetN), .kp(kp_a));

  keypad_scanner_debounced #(.ROWS(4), .COLS(3), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3),
                             .REPEAT_SCANS(5), .KEY_BITS(4)) dut_rep (
    .scanClock(scanClock), .resetN(resetN), .kp(kp_b));

  initial forever #5 scanClock = ~scanClock;

  // ideal keypad matrix: a row reads high when a pressed key sits on a driven column
  always_comb begin
    rows_a = '0;
    rows_b = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r * 3 + c] && kp_a.columnDrivers_reg[c]) rows_a[r] = 1'b1;
        if (pressed[r * 3 + c] && kp_b.columnDrivers_reg[c]) rows_b[r] = 1'b1;
      end
    end
  end
  assign kp_a.rowReceivers = rows_a;
  assign kp_b.rowReceivers = rows_b;

  function automatic logic [11:0] key_mask(input int k);
    return 12'(1) << k;
  endfunction

  task automatic model_clear();
    m_held = 1'b0; m_key = 0; m_code = 0; m_run = 0; m_rel = 0; m_rep = 0;
  endtask

  // one full scan of keypad contents -> expected events, from the debounce rules
  task automatic model_step(input logic [11:0] m);
    int n;
    int k;
    n = $countones(m);
    k = -1;
    for (int i = 0; i < 12; i++) if (m[i]) k = i;
    exp_v = 1'b0;
    exp_r = 1'b0;
    exp_multi = (n >= 2);
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && m_code == k) m_run++;
        else begin m_code = k; m_run = 1; end
        if (m_run >= DEB) begin
          m_held = 1'b1; m_key = k; exp_v = 1'b1; m_rel = 0; m_rep = 0; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_rel++;
        if (m_rel == DEB) begin m_held = 1'b0; exp_r = 1'b1; m_rel = 0; m_run = 0; end
      end else if (n == 1 && k == m_key) begin
        m_rel = 0;
        if (m_r > 0) begin
          m_rep++;
          if (m_rep == m_r) begin exp_v = 1'b1; m_rep = 0; end
        end
      end else begin
        m_rel = 0;
      end
    end
    exp_key  = 4'(m_key);
    exp_held = m_held;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    model_clear();
    repeat (2) @(posedge scanClock);
    @(negedge scanClock);
    resetN = 1'b1;
    @(posedge scanClock);
    #1;
    edge_no = 1;
    first_valid_edge = 0;
  endtask

  // hold the keypad steady for one full scan and record what the selected DUT shows
  task automatic run_scan(input logic [11:0] m);
    logic v, rr;
    pressed = m;
    model_step(m);
    obs_vcnt = 0;
    obs_rcnt = 0;
    v = 1'b0;
    rr = 1'b0;
    for (int i = 0; i < SCAN_CLKS; i++) begin
      @(posedge scanClock);
      #1;
      edge_no++;
      v  = sel_rep ? kp_b.keyValid : kp_a.keyValid;
      rr = sel_rep ? kp_b.keyReleased : kp_a.keyReleased;
      if (v === 1'b1) begin
        obs_vcnt++;
        if (first_valid_edge == 0) first_valid_edge = edge_no;
      end
      if (rr === 1'b1) obs_rcnt++;
    end
    obs_vend  = v;
    obs_rend  = rr;
    obs_key   = sel_rep ? kp_b.key_reg : kp_a.key_reg;
    obs_held  = sel_rep ? kp_b.keyHeld : kp_a.keyHeld;
    obs_multi = sel_rep ? kp_b.multiKey : kp_a.multiKey;
  endtask

  task automatic test_reset();
    pressed = '0;
    resetN = 1'b0;
    repeat (2) @(posedge scanClock);
    #1;
    n_checks++;
    if (kp_a.columnDrivers_reg !== 3'b000 || kp_b.columnDrivers_reg !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_drivers: got %b/%b expected 000", kp_a.columnDrivers_reg, kp_b.columnDrivers_reg);
    end
    n_checks++;
    if (kp_a.key_reg !== 4'd0 || kp_b.key_reg !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_key: got %0d/%0d expected 0", kp_a.key_reg, kp_b.key_reg);
    end
    n_checks++;
    if ({kp_a.keyValid, kp_a.keyHeld, kp_a.keyReleased, kp_a.multiKey} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {kp_a.keyValid, kp_a.keyHeld, kp_a.keyReleased, kp_a.multiKey});
    end
    @(negedge scanClock);
    resetN = 1'b1;
    @(posedge scanClock);
    #1;
    n_checks++;
    if (kp_a.columnDrivers_reg !== 3'b001) begin
      n_errors++;
      $display("FAIL first_column: got %b expected 001", kp_a.columnDrivers_reg);
    end
    repeat (3) @(posedge scanClock);
    #1;
    n_checks++;
    if (kp_a.columnDrivers_reg !== 3'b001) begin
      n_errors++;
      $display("FAIL settle_hold: got %b expected 001", kp_a.columnDrivers_reg);
    end
    @(posedge scanClock);
    #1;
    n_checks++;
    if (kp_a.columnDrivers_reg !== 3'b010) begin
      n_errors++;
      $display("FAIL column_step: got %b expected 010", kp_a.columnDrivers_reg);
    end
  endtask

  task automatic test_single_press();
    int nv = 0;
    sel_rep = 1'b0; m_r = 0; pressed = '0;
    do_reset();
    for (int s = 1; s <= 5; s++) begin
      run_scan(key_mask(7));
      nv += obs_vcnt;
      n_checks++;
      if (obs_vcnt != int'(exp_v) || obs_vend !== exp_v) begin
        n_errors++;
        $display("FAIL press_valid scan %0d: count=%0d end=%b expected %b", s, obs_vcnt, obs_vend, exp_v);
      end
      n_checks++;
      if (obs_key !== exp_key || obs_held !== exp_held || obs_multi !== exp_multi) begin
        n_errors++;
        $display("FAIL press_state scan %0d: key=%0d held=%b multi=%b expected %0d %b %b",
                 s, obs_key, obs_held, obs_multi, exp_key, exp_held, exp_multi);
      end
    end
    n_checks++;
    if (first_valid_edge != 37 || nv != 1) begin
      n_errors++;
      $display("FAIL press_latency: edge=%0d pulses=%0d expected edge 37, 1 pulse", first_valid_edge, nv);
    end
  endtask

  task automatic test_bounce();
    int seq[5] = '{7, -1, 7, 7, 7};
    int nv = 0;
    sel_rep = 1'b0; m_r = 0; pressed = '0;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      run_scan(seq[s] < 0 ? 12'd0 : key_mask(seq[s]));
      nv += obs_vcnt;
      n_checks++;
      if (obs_vcnt != int'(exp_v) || obs_vend !== exp_v || obs_key !== exp_key || obs_held !== exp_held) begin
        n_errors++;
        $display("FAIL bounce scan %0d: valid=%0d key=%0d held=%b expected %b %0d %b",
                 s + 1, obs_vcnt, obs_key, obs_held, exp_v, exp_key, exp_held);
      end
    end
    n_checks++;
    if (nv != 1 || first_valid_edge != 5 * SCAN_CLKS + 1) begin
      n_errors++;
      $display("FAIL bounce_once: pulses=%0d edge=%0d expected 1 at %0d", nv, first_valid_edge, 5 * SCAN_CLKS + 1);
    end
  endtask

  task automatic test_release();
    int seq[11] = '{7, 7, 7, 7, -1, -1, 7, -1, -1, -1, -1};
    int rel_scan = 0;
    int nr = 0;
    sel_rep = 1'b0; m_r = 0; pressed = '0;
    do_reset();
    for (int s = 0; s < 11; s++) begin
      run_scan(seq[s] < 0 ? 12'd0 : key_mask(seq[s]));
      nr += obs_rcnt;
      if (obs_rcnt > 0 && rel_scan == 0) rel_scan = s + 1;
      n_checks++;
      if (obs_rcnt != int'(exp_r) || obs_rend !== exp_r || obs_held !== exp_held) begin
        n_errors++;
        $display("FAIL release scan %0d: released=%0d end=%b held=%b expected %b %b",
                 s + 1, obs_rcnt, obs_rend, obs_held, exp_r, exp_held);
      end
      n_checks++;
      if (obs_vcnt != int'(exp_v) || obs_key !== exp_key) begin
        n_errors++;
        $display("FAIL release_key scan %0d: valid=%0d key=%0d expected %b %0d", s + 1, obs_vcnt, obs_key, exp_v, exp_key);
      end
    end
    n_checks++;
    if (rel_scan != 10 || nr != 1) begin
      n_errors++;
      $display("FAIL release_point: scan=%0d pulses=%0d expected scan 10, 1 pulse", rel_scan, nr);
    end
  endtask

  task automatic test_multi();
    logic [11:0] seq[13];
    int nv_multi = 0;
    sel_rep = 1'b0; m_r = 0; pressed = '0;
    for (int s = 0; s < 3; s++) seq[s] = key_mask(0) | key_mask(9);
    for (int s = 3; s < 6; s++) seq[s] = key_mask(0);
    for (int s = 6; s < 9; s++) seq[s] = '0;
    seq[9] = key_mask(0) | key_mask(9);
    for (int s = 10; s < 13; s++) seq[s] = key_mask(9);
    do_reset();
    for (int s = 0; s < 13; s++) begin
      run_scan(seq[s]);
      if (s < 3) nv_multi += obs_vcnt;
      n_checks++;
      if (obs_vcnt != int'(exp_v) || obs_rcnt != int'(exp_r)) begin
        n_errors++;
        $display("FAIL multi_strobes scan %0d: valid=%0d released=%0d expected %b %b", s + 1, obs_vcnt, obs_rcnt, exp_v, exp_r);
      end
      n_checks++;
      if (obs_key !== exp_key || obs_held !== exp_held || obs_multi !== exp_multi) begin
        n_errors++;
        $display("FAIL multi_state scan %0d: key=%0d held=%b multi=%b expected %0d %b %b",
                 s + 1, obs_key, obs_held, obs_multi, exp_key, exp_held, exp_multi);
      end
      if (s == 2) begin
        n_checks++;
        if (obs_multi !== 1'b1 || nv_multi != 0 || obs_key !== 4'd0) begin
          n_errors++;
          $display("FAIL multi_block: multi=%b pulses=%0d key=%0d expected 1 0 0", obs_multi, nv_multi, obs_key);
        end
      end
    end
    n_checks++;
    if (kp_a.key_reg !== 4'd9) begin
      n_errors++;
      $display("FAIL multi_final_key: got %0d expected 9", kp_a.key_reg);
    end
  endtask

  task automatic test_repeat();
    int nv = 0;
    sel_rep = 1'b1; m_r = 5; pressed = '0;
    do_reset();
    for (int s = 1; s <= 23; s++) begin
      run_scan(key_mask(11));
      nv += obs_vcnt;
      n_checks++;
      if (obs_vcnt != int'(exp_v) || obs_vend !== exp_v || obs_key !== exp_key || obs_held !== exp_held) begin
        n_errors++;
        $display("FAIL repeat scan %0d: valid=%0d key=%0d held=%b expected %b %0d %b",
                 s, obs_vcnt, obs_key, obs_held, exp_v, exp_key, exp_held);
      end
    end
    n_checks++;
    if (nv != 5) begin
      n_errors++;
      $display("FAIL repeat_total: got %0d pulses expected 5", nv);
    end
    sel_rep = 1'b0; m_r = 0;
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    sel_rep = 1'b0; m_r = 0; pressed = '0;
    do_reset();
    run_scan(key_mask(7));
    run_scan(key_mask(7));
    repeat (5) @(posedge scanClock);
    #1;
    resetN = 1'b0;
    #1;
    n_checks++;
    if (kp_a.columnDrivers_reg !== 3'b000 || kp_a.key_reg !== 4'd0 ||
        {kp_a.keyValid, kp_a.keyHeld, kp_a.keyReleased, kp_a.multiKey} !== 4'b0000) begin
      n_errors++;
      $display("FAIL async_reset: drivers=%b key=%0d flags=%b expected all 0", kp_a.columnDrivers_reg, kp_a.key_reg,
               {kp_a.keyValid, kp_a.keyHeld, kp_a.keyReleased, kp_a.multiKey});
    end
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      run_scan(key_mask(7));
      nv += obs_vcnt;
      n_checks++;
      if (obs_vcnt != int'(exp_v) || obs_key !== exp_key || obs_held !== exp_held) begin
        n_errors++;
        $display("FAIL reset_mid scan %0d: valid=%0d key=%0d held=%b expected %b %0d %b",
                 s, obs_vcnt, obs_key, obs_held, exp_v, exp_key, exp_held);
      end
    end
    n_checks++;
    if (first_valid_edge != 37 || nv != 1) begin
      n_errors++;
      $display("FAIL reset_mid_latency: edge=%0d pulses=%0d expected 37, 1", first_valid_edge, nv);
    end
  endtask

  task automatic test_random();
    logic [11:0] m;
    int hold, pick, a, b;
    for (int round = 0; round < 2; round++) begin
      sel_rep = (round == 1);
      m_r = sel_rep ? 5 : 0;
      pressed = '0;
      m = '0;
      hold = 0;
      do_reset();
      for (int s = 1; s <= 100; s++) begin
        if (hold == 0) begin
          pick = $urandom_range(0, 9);
          if (pick < 4) m = '0;
          else if (pick < 9) m = key_mask(pick < 6 ? 7 : int'($urandom_range(0, 11)));
          else begin
            a = $urandom_range(0, 11);
            b = (a + 1 + $urandom_range(0, 10)) % 12;
            m = key_mask(a) | key_mask(b);
          end
          hold = $urandom_range(1, 8);
        end
        hold--;
        run_scan(m);
        n_checks++;
        if (obs_vcnt != int'(exp_v) || obs_vend !== exp_v || obs_rcnt != int'(exp_r) || obs_rend !== exp_r) begin
          n_errors++;
          $display("FAIL random_strobes r%0d scan %0d: valid=%0d/%b released=%0d/%b expected %b %b",
                   round, s, obs_vcnt, obs_vend, obs_rcnt, obs_rend, exp_v, exp_r);
        end
        n_checks++;
        if (obs_key !== exp_key || obs_held !== exp_held || obs_multi !== exp_multi) begin
          n_errors++;
          $display("FAIL random_state r%0d scan %0d: key=%0d held=%b multi=%b expected %0d %b %b",
                   round, s, obs_key, obs_held, obs_multi, exp_key, exp_held, exp_multi);
        end
      end
    end
    sel_rep = 1'b0; m_r = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_release();
    test_multi();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner_debounced.md
Name: keypad_scanner_debounced

Overview:
Parametrised successor to the fixed 3x4 keypad scanner. It drives COLS column lines one-hot, samples ROWS row receivers and reduces each full scan to one of three results: none, single key, or multiple keys. It debounces presses and releases over whole scans and reports a registered key code with valid/held/released strobes. Optional auto-repeat is included. It sits between the pads and the display/decoder logic, clocked from the ripple-scaled scan clock.

Parameters:
ROWS, 4, number of row receiver lines (>=1)
COLS, 3, number of column driver lines (>=2)
SETTLE_CYCLES, 4, clocks each column is driven; rows are sampled on the last clock of the slot (>=1)
DEBOUNCE_SCANS, 3, consecutive identical full-scan results required to accept a press or a release (>=1)
REPEAT_SCANS, 0, full scans of continuous hold between repeat keyValid pulses; 0 disables repeat
KEY_BITS, clog2(ROWS*COLS), width of keyCode

Ports:
scanClock  input  1  scan clock; all state changes on its rising edge
resetN  input  1  asynchronous, active-low reset
rowReceivers  input  ROWS  row lines; pulled down, high = contact
columnDrivers_reg  output  COLS  registered one-hot column drive, active high
key_reg  output  KEY_BITS  last accepted key code, row*COLS+col
keyValid  output  1  one-clock strobe: new press accepted, or a repeat
keyHeld  output  1  level: a debounced key is currently held
keyReleased  output  1  one-clock strobe: debounced release
multiKey  output  1  level: the most recent full scan saw two or more contacts

Behaviour:
- Reset (resetN low, async): columnDrivers_reg=0, key_reg=0, keyValid=0, keyHeld=0, keyReleased=0, multiKey=0. The FSM goes to IDLE and all counters clear. The first clock after release drives column 0.
- Scan sequencer: column index c = 0..COLS-1, then wraps to 0. Each slot lasts SETTLE_CYCLES clocks. On the last clock of a slot, rowReceivers is sampled against column c. A full scan takes COLS*SETTLE_CYCLES clocks.
- Scan accumulation: contact count saturates at 2. The code of the single contact is row*COLS+c; the lowest row index wins within a column only for code capture, and the count still records multiple.
- End of scan: the result is classified as NONE, SINGLE(code) or MULTI. multiKey updates on the same edge. The accumulator clears for the next scan with no gap cycle.
- All FSM decisions happen on the end-of-scan edge. Strobes are asserted the following clock, for exactly one clock.
- IDLE:
  - SINGLE: candidate=code, count=1. If DEBOUNCE_SCANS==1, accept immediately; else go to PRESS_CHECK.
  - NONE or MULTI: stay in IDLE.
- PRESS_CHECK:
  - SINGLE with the same code: count++. On reaching DEBOUNCE_SCANS, accept.
  - SINGLE with a different code: restart with candidate=new code, count=1.
  - NONE or MULTI: go to IDLE.
- Accept: key_reg=candidate, keyValid pulse, keyHeld=1, relCount=0, repCount=0, go to HELD.
- HELD:
  - NONE: relCount++. On reaching DEBOUNCE_SCANS: keyHeld=0, keyReleased pulse, go to IDLE. key_reg is retained.
  - SINGLE with the same code: relCount=0 and repCount++. If REPEAT_SCANS>0 and repCount reaches REPEAT_SCANS: keyValid pulse, repCount=0.
  - MULTI or a different code: relCount=0 and repCount holds. The press of a second key is not reported until a full release.
- key_reg changes only on accept.
- keyValid and keyReleased are never high in the same clock.
- Counter widths are sized to their parameter maximum. Counters must not wrap at any legal parameter value.
- Reset asserted mid-scan or mid-debounce aborts immediately with no strobe.

Test Plan:
1. Defaults; press row2/col1 held throughout -> keyValid is a single pulse at clock 12*3+1 after the first full scan begins; key_reg=7; keyHeld=1.
2. Contact bounces: present scan 1, absent scan 2, present scans 3-5 -> exactly one keyValid, at the end of scan 5 +1 clock; key_reg=7.
3. Hold, then release for 2 scans, then re-contact, then release for 3 scans -> no keyReleased after the 2-scan gap; keyReleased after the 3rd empty scan; keyHeld falls on the same clock.
4. Rows 0 and 3 both high in col 0 -> multiKey=1, no keyValid, key_reg remains 0; clearing one row for 3 scans -> keyValid with key_reg=0 or 9 accordingly.
5. REPEAT_SCANS=5, key 11 held for 3+20 scans -> 1 initial keyValid plus 4 repeats; key_reg=11 throughout.
6. Assert resetN mid-PRESS_CHECK (after scan 2) -> all outputs 0 asynchronously; after release with the key still held, keyValid arrives only after 3 fresh full scans.
